// File: rtl/pipe_if_stage.sv
// pipe_if_stage: instruction-fetch stage plus IF/ID pipeline register.
// Latency: a fetched word reaches IDinst one cycle after imem_ready=1 at its address.
// Backpressure: IFwip=0 holds the PC, IDwir=0 holds IF/ID, imem_ready=0 inserts bubbles.
//
// Ports:
//   clock, resetn           rising-edge clock, asynchronous active-low reset
//   IFwip, IDwir            PC / IF-ID write enables from ID control
//   pcsource, bpc/rpc/jpc   next-PC select (00 pc+4, 01 bpc, 10 rpc, 11 jpc) and targets
//   imem_addr               fetch address (PC, combinational)
//   imem_rdata, imem_ready  fetched word and its valid strobe
//   IDinst, IDpc4, IDvalid  IF/ID register contents
// Optional macro IF_PERF_CNT_EN adds perf_stall_cnt / perf_bubble_cnt (wrapping 32-bit).
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned DELAY_SLOT = 1,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        IFwip,
  input  logic        IDwir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IDinst,
  output logic [31:0] IDpc4,
  output logic        IDvalid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef enum logic {RUN, REDIR_PEND} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend_tgt, pend_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  logic        load_bubble;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // A redirect is only real when ID holds an actual instruction.
  assign redirect = IDvalid && (pcsource != 2'b00);

  always_comb begin
    target = bpc;
    case (pcsource)
      2'b10:   target = rpc;
      2'b11:   target = jpc;
      default: target = bpc;
    endcase
  end

  // Bubble when no word arrived, or when the word behind a taken
  // redirect must be squashed (no delay slot).
  assign load_bubble = !imem_ready || (redirect && (DELAY_SLOT == 0));

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_tgt;
    case (state)
      RUN: begin
        if (IFwip) begin
          if (redirect) begin
            if (imem_ready || (DELAY_SLOT == 0)) begin
              // Either the delay-slot word is arriving now, or there is
              // no delay slot and the outstanding fetch is abandoned.
              pc_nxt = target;
            end else begin
              // Delay-slot word still outstanding: park the target.
              pend_nxt  = target;
              state_nxt = REDIR_PEND;
            end
          end else if (imem_ready) begin
            pc_nxt = pc_plus4;
          end
        end
      end
      REDIR_PEND: begin
        // Redirect inputs are ignored here; IF/ID holds a bubble.
        if (IFwip && imem_ready) begin
          pc_nxt    = pend_tgt;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= RUN;
      pc       <= RESET_PC;
      pend_tgt <= 32'h0000_0000;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pend_tgt <= pend_nxt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      IDinst  <= NOP_INST;
      IDpc4   <= 32'h0000_0000;
      IDvalid <= 1'b0;
    end else if (IDwir) begin
      IDpc4 <= pc_plus4;
      if (load_bubble) begin
        IDinst  <= NOP_INST;
        IDvalid <= 1'b0;
      end else begin
        IDinst  <= imem_rdata;
        IDvalid <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cnt  <= 32'h0000_0000;
      perf_bubble_cnt <= 32'h0000_0000;
    end else begin
      if (!IFwip)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (IDwir && load_bubble)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
module tb_pipe_if_stage;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        IFwip = 1'b1;
  logic        IDwir = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0, rpc = '0, jpc = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] rdata_d [2];
  logic [31:0] addr_w  [2];
  logic [31:0] inst_w  [2];
  logic [31:0] pc4_w   [2];
  logic        valid_w [2];
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_w [2];
  logic [31:0] bub_w   [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Index 0: no delay slot, index 1: delay slot.
  pipe_if_stage #(.RESET_PC(32'h0), .DELAY_SLOT(0), .NOP_INST(32'h0)) d0 (
    .clock(clock), .resetn(resetn), .IFwip(IFwip), .IDwir(IDwir),
    .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .imem_addr(addr_w[0]), .imem_rdata(rdata_d[0]), .imem_ready(imem_ready),
    .IDinst(inst_w[0]), .IDpc4(pc4_w[0]), .IDvalid(valid_w[0])
`ifdef IF_PERF_CNT_EN
    , .perf_stall_cnt(stall_w[0]), .perf_bubble_cnt(bub_w[0])
`endif
  );

  pipe_if_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1), .NOP_INST(32'h0)) d1 (
    .clock(clock), .resetn(resetn), .IFwip(IFwip), .IDwir(IDwir),
    .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .imem_addr(addr_w[1]), .imem_rdata(rdata_d[1]), .imem_ready(imem_ready),
    .IDinst(inst_w[1]), .IDpc4(pc4_w[1]), .IDvalid(valid_w[1])
`ifdef IF_PERF_CNT_EN
    , .perf_stall_cnt(stall_w[1]), .perf_bubble_cnt(bub_w[1])
`endif
  );

  // Reference model: architectural state per DUT.
  logic [31:0] m_pc [2], m_tgt [2], m_inst [2], m_pc4 [2];
  logic        m_pend [2], m_valid [2];
  logic [31:0] m_stall [2], m_bub [2];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_tgt[k] = 32'h0; m_pend[k] = 1'b0;
      m_inst[k] = 32'h0; m_pc4[k] = 32'h0; m_valid[k] = 1'b0;
      m_stall[k] = 32'h0; m_bub[k] = 32'h0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      logic        ds, redir, bubble;
      logic [31:0] tgt, npc;
      ds     = (k == 1);
      redir  = m_valid[k] && (pcsource != 2'b00);
      tgt    = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? rpc : jpc;
      bubble = !imem_ready || (redir && !ds);
      npc    = m_pc[k];
      if (m_pend[k]) begin
        if (IFwip && imem_ready) begin npc = m_tgt[k]; m_pend[k] = 1'b0; end
      end else if (IFwip) begin
        if (redir) begin
          if (imem_ready || !ds) npc = tgt;
          else begin m_pend[k] = 1'b1; m_tgt[k] = tgt; end
        end else if (imem_ready) npc = m_pc[k] + 32'd4;
      end
      if (IDwir) begin
        m_pc4[k]   = m_pc[k] + 32'd4;
        m_inst[k]  = bubble ? 32'h0 : rdata_d[k];
        m_valid[k] = !bubble;
        if (bubble) m_bub[k] = m_bub[k] + 32'd1;
      end
      if (!IFwip) m_stall[k] = m_stall[k] + 32'd1;
      m_pc[k] = npc;
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d imem_addr", k), addr_w[k], m_pc[k]);
      chk($sformatf("d%0d IDinst", k), inst_w[k], m_inst[k]);
      chk($sformatf("d%0d IDpc4", k), pc4_w[k], m_pc4[k]);
      chk($sformatf("d%0d IDvalid", k), {31'b0, valid_w[k]}, {31'b0, m_valid[k]});
`ifdef IF_PERF_CNT_EN
      chk($sformatf("d%0d perf_stall", k), stall_w[k], m_stall[k]);
      chk($sformatf("d%0d perf_bubble", k), bub_w[k], m_bub[k]);
`endif
    end
  endtask

  task automatic step(input logic wip, input logic wir, input logic rdy, input logic [1:0] src,
                      input logic [31:0] b, input logic [31:0] r, input logic [31:0] j,
                      input logic rnd_data);
    @(negedge clock);
    IFwip = wip; IDwir = wir; imem_ready = rdy; pcsource = src;
    bpc = b; rpc = r; jpc = j;
    for (int k = 0; k < 2; k++) rdata_d[k] = rnd_data ? $urandom : pat(m_pc[k]);
    @(posedge clock);
    model_clock();
    #1;
    compare_model();
  endtask

  // Reset asserted mid-cycle; checked while still in reset (asynchronous).
  task automatic do_reset();
    @(negedge clock);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    compare_model();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic        wip, wir, rdy;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] e_addr, e_inst, e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t tbl [17];

  initial begin
    rdata_d[0] = '0; rdata_d[1] = '0;
    model_reset();

    // Delay-slot DUT expectations (d1), derived by hand from the fetch rules.
    tbl[0]  = '{1,1,1,2'd0,32'h0,   32'h004, pat(32'h000), 32'h004, 1};
    tbl[1]  = '{1,1,1,2'd0,32'h0,   32'h008, pat(32'h004), 32'h008, 1};
    tbl[2]  = '{1,1,1,2'd0,32'h0,   32'h00C, pat(32'h008), 32'h00C, 1};
    tbl[3]  = '{1,1,1,2'd0,32'h0,   32'h010, pat(32'h00C), 32'h010, 1};
    tbl[4]  = '{0,0,1,2'd0,32'h0,   32'h010, pat(32'h00C), 32'h010, 1}; // load-use
    tbl[5]  = '{1,1,1,2'd0,32'h0,   32'h014, pat(32'h010), 32'h014, 1};
    tbl[6]  = '{1,1,1,2'd0,32'h0,   32'h018, pat(32'h014), 32'h018, 1};
    tbl[7]  = '{1,1,1,2'd0,32'h0,   32'h01C, pat(32'h018), 32'h01C, 1};
    tbl[8]  = '{1,1,1,2'd0,32'h0,   32'h020, pat(32'h01C), 32'h020, 1};
    tbl[9]  = '{1,1,1,2'd1,32'h100, 32'h100, pat(32'h020), 32'h024, 1}; // branch, slot kept
    tbl[10] = '{1,1,1,2'd0,32'h0,   32'h104, pat(32'h100), 32'h104, 1};
    tbl[11] = '{1,1,0,2'd1,32'h200, 32'h104, 32'h0,        32'h108, 0}; // branch in wait
    tbl[12] = '{1,1,0,2'd2,32'h300, 32'h104, 32'h0,        32'h108, 0}; // ignored
    tbl[13] = '{1,1,0,2'd0,32'h0,   32'h104, 32'h0,        32'h108, 0};
    tbl[14] = '{1,1,1,2'd0,32'h0,   32'h200, pat(32'h104), 32'h108, 1}; // slot captured
    tbl[15] = '{1,1,1,2'd0,32'h0,   32'h204, pat(32'h200), 32'h204, 1};
    tbl[16] = '{1,1,0,2'd1,32'h400, 32'h204, 32'h0,        32'h208, 0}; // enter pending

    repeat (2) @(negedge clock);
    chk("reset imem_addr", addr_w[1], 32'h0);
    chk("reset IDinst", inst_w[1], 32'h0);
    chk("reset IDvalid", {31'b0, valid_w[1]}, 32'h0);
    compare_model();
    resetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].wip, tbl[i].wir, tbl[i].rdy, tbl[i].src, tbl[i].tgt, tbl[i].tgt, tbl[i].tgt, 1'b0);
      chk($sformatf("vec%0d imem_addr", i), addr_w[1], tbl[i].e_addr);
      chk($sformatf("vec%0d IDinst", i), inst_w[1], tbl[i].e_inst);
      chk($sformatf("vec%0d IDpc4", i), pc4_w[1], tbl[i].e_pc4);
      chk($sformatf("vec%0d IDvalid", i), {31'b0, valid_w[1]}, {31'b0, tbl[i].e_valid});
    end

    // Reset while d1 waits with a parked target: target must be forgotten.
    do_reset();
    chk("rst-pend imem_addr", addr_w[1], 32'h0);
    chk("rst-pend IDvalid", {31'b0, valid_w[1]}, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("rst-pend stall cnt", stall_w[1], 32'h0);
    chk("rst-pend bubble cnt", bub_w[1], 32'h0);
`endif
    step(1, 1, 1, 2'd0, 0, 0, 0, 1'b0);
    chk("post-rst imem_addr", addr_w[1], 32'h4);
    chk("post-rst IDinst", inst_w[1], pat(32'h0));

    // No-delay-slot jump: the word behind the jump is squashed.
    step(1, 1, 1, 2'd0, 0, 0, 0, 1'b0);
    step(1, 1, 1, 2'd3, 32'h0, 32'h0, 32'h40, 1'b0);
    chk("ds0 jump imem_addr", addr_w[0], 32'h40);
    chk("ds0 jump IDvalid", {31'b0, valid_w[0]}, 32'h0);
    chk("ds0 jump IDinst", inst_w[0], 32'h0);
    step(1, 1, 1, 2'd0, 0, 0, 0, 1'b0);
    chk("ds0 after jump imem_addr", addr_w[0], 32'h44);
    // No-delay-slot redirect during a wait abandons the fetch.
    step(1, 1, 0, 2'd2, 32'h0, 32'h80, 32'h0, 1'b0);
    chk("ds0 wait-redirect imem_addr", addr_w[0], 32'h80);
    chk("ds0 wait-redirect IDvalid", {31'b0, valid_w[0]}, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic        wip, wir, rdy;
      logic [1:0]  src;
      wip = ($urandom_range(0, 7) != 0);
      wir = ($urandom_range(0, 15) == 0) ? ~wip : wip;
      rdy = ($urandom_range(0, 3) != 0);
      src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      step(wip, wir, rdy, src, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
           $urandom & 32'hFFFF_FFFC, 1'b1);
      if (i == 300) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipeline; directly upstream of the ID-stage control unit.
- Holds the PC, computes the next PC from the ID-stage pcsource selection, and drives the instruction-memory address.
- Captures fetched words into IF/ID under the ID-stage stall enables IFwip/IDwir.
- Absorbs instruction-memory wait states; never loses a branch/jump redirect or its delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- DELAY_SLOT, 1, 1 = instruction after a branch/jump executes (MIPS delay slot); 0 = it is squashed to a bubble.
- NOP_INST, 32'h0000_0000, bubble word inserted into IF/ID.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- IFwip  in  1  PC write enable from ID control (0 = load-use stall)
- IDwir  in  1  IF/ID write enable from ID control (0 = hold IF/ID)
- pcsource  in  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc, 11 jpc
- bpc  in  32  branch target
- rpc  in  32  register target (jr)
- jpc  in  32  jump target
- imem_addr  out  32  fetch address (= PC, combinational)
- imem_rdata  in  32  fetched instruction
- imem_ready  in  1  imem_rdata valid for imem_addr this cycle
- IDinst  out  32  IF/ID instruction
- IDpc4  out  32  IF/ID PC+4 of IDinst
- IDvalid  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, resetn=0): PC=RESET_PC, IDinst=NOP_INST, IDpc4=0, IDvalid=0, state=RUN, pend_tgt=0. Release takes effect on the next rising edge; reset mid-wait or mid-redirect discards everything.
- redirect = IDvalid & (pcsource!=00). target = bpc/rpc/jpc per pcsource. PC+4 wraps modulo 2^32.
- State RUN:
  - IFwip=0: PC held; redirect ignored (ID instruction is also stalled and re-presents it).
  - IFwip=1, redirect=1, imem_ready=1: PC<=target.
  - IFwip=1, redirect=1, imem_ready=0, DELAY_SLOT=1: pend_tgt<=target; PC held; go to REDIR_PEND.
  - IFwip=1, redirect=1, imem_ready=0, DELAY_SLOT=0: PC<=target (abandon the fetch).
  - IFwip=1, no redirect: PC<=PC+4 when imem_ready=1, else held.
- State REDIR_PEND (waiting for the delay-slot word):
  - IFwip=1 and imem_ready=1: PC<=pend_tgt; go to RUN.
  - Otherwise: PC held; stay in REDIR_PEND.
  - A new redirect cannot arrive here because IF/ID holds a bubble. Any redirect input in this state is ignored.
- IF/ID register (all three fields update together):
  - IDwir=0: hold.
  - IDwir=1, imem_ready=0: load bubble (NOP_INST, IDvalid=0; IDpc4 = PC+4).
  - IDwir=1, imem_ready=1, redirect=1, DELAY_SLOT=0: load bubble (squash).
  - Otherwise: IDinst<=imem_rdata, IDpc4<=PC+4, IDvalid<=1.
- IFwip=0 with IDwir=1 is not produced by ID control. If it occurs, IF/ID still follows the rules above.
- No combinational path from imem_rdata to any output; imem_addr depends only on PC.
- Latency: a word appears on IDinst one cycle after imem_ready=1 at its address.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_bubble_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - perf_stall_cnt increments each cycle with IFwip=0.
  - perf_bubble_cnt increments each cycle IF/ID loads a bubble.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then imem_ready=1 continuously with imem_rdata=PC-derived pattern → imem_addr 0,4,8,C; IDinst follows one cycle later; IDvalid=1 from the second edge.
- Load-use: IFwip=IDwir=0 for 1 cycle at PC=0x10 → PC stays 0x10; IDinst/IDpc4 unchanged; fetch resumes at 0x14 next.
- Branch, DELAY_SLOT=1: ID branch with pcsource=01, bpc=0x100 at PC=0x20 → delay-slot word from 0x20 enters ID; next imem_addr=0x100.
- Branch during wait: pcsource=01, bpc=0x200, imem_ready=0 for 3 cycles → 3 bubbles; PC held; delay slot captured when ready rises; then imem_addr=0x200.
- DELAY_SLOT=0, jump pcsource=11, jpc=0x40 → next IF/ID IDvalid=0, IDinst=0; imem_addr=0x40.
- Assert resetn=0 while in REDIR_PEND → PC=RESET_PC, IDvalid=0, pending target discarded; with IF_PERF_CNT_EN, both counters read 0.
